// File: rtl/matrix_stream_packer.sv
// matrix_stream_packer: frames a row-major DIMxDIM entry stream into a held packed matrix word
// Ports: clk, rst (async, active-high)
//        in_data/in_valid/in_last/in_ready : entry stream, one entry per accept
//        A_new : packed matrix, entry (r,c) at [(DIM*r+c)*DATA_W +: DATA_W]
//        enable : matrix complete and held; mat_ack : consumer releases it
//        subdiag_nz : bit k = entry (k+1,k) nonzero; framing_err : one-cycle violation pulse
module matrix_stream_packer #(
   parameter int DATA_W = 16,
   parameter int DIM    = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [DATA_W-1:0]          in_data,
   input  logic                       in_valid,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic [DIM*DIM*DATA_W-1:0]  A_new,
   output logic                       enable,
   input  logic                       mat_ack,
   output logic [DIM-2:0]             subdiag_nz,
   output logic                       framing_err
);
   localparam int N  = DIM*DIM;
   localparam int IW = $clog2(N);
   typedef enum logic {FILL, HOLD} state_t;
   state_t                r_state;
   logic [IW-1:0]         r_idx;
   logic [N*DATA_W-1:0]   r_a;
   logic [N*DATA_W-1:0]   w_a;
   logic [DIM-2:0]        r_sub;
   logic [DIM-2:0]        w_sub;
   logic                  r_err;
   logic                  w_acc;
   logic                  w_end;
   assign w_acc = in_valid && r_state == FILL;
   assign w_end = r_idx == IW'(N-1);
   // matrix contents as they will be after this edge, so the final entry counts toward subdiag_nz
   always_comb begin
      w_a = r_a;
      if (w_acc) w_a[r_idx*DATA_W +: DATA_W] = in_data;
   end
   for (genvar k = 0; k < DIM-1; k++) begin : g_sub
      assign w_sub[k] = |w_a[((DIM+1)*k+DIM)*DATA_W +: DATA_W];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FILL;
         r_idx   <= '0;
         r_a     <= '0;
         r_sub   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         r_a   <= w_a;
         if (r_state == FILL) begin
            if (w_acc) begin
               r_idx <= (w_end || in_last) ? '0 : r_idx + 1'b1;
               // error when in_last disagrees with the slot position
               r_err <= w_end ^ in_last;
               if (w_end) begin
                  r_state <= HOLD;
                  r_sub   <= w_sub;
               end
            end
         end else if (mat_ack) begin
            r_state <= FILL;
         end
      end
   end
   assign in_ready    = !rst && r_state == FILL;
   assign enable      = r_state == HOLD;
   assign A_new       = r_a;
   assign subdiag_nz  = r_sub;
   assign framing_err = r_err;
endmodule

// File: doc/matrix_stream_packer.md
# matrix_stream_packer

Input-side framer for the eigenvalue datapath. It accepts a 4x4 matrix of 16-bit entries, one entry per cycle, over a valid/ready stream in row-major order, and assembles them into the packed 256-bit `A_new` word. It then holds that word stable, with `enable` asserted, until the downstream 2x2 eigenvalue stage acknowledges it. It also flags which sub-diagonal entries are nonzero, so the consumer knows which diagonal 2x2 blocks carry complex-conjugate pairs.

## Interface
- `DATA_W`, 16: width of one matrix entry; fixed at 16 for this datapath.
- `DIM`, 4: matrix dimension; the packed width is DIM*DIM*DATA_W = 256.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset; asynchronous, active-high.
- `in_data` input 16: matrix entry.
- `in_valid` input 1: `in_data` is valid.
- `in_last` input 1: marks the final entry of a matrix.
- `in_ready` output 1: the packer accepts an entry this cycle.
- `A_new` output 256: packed matrix, registered. Entry (r,c), with 0-based r and c, sits at bits [(4r+c)*16 +: 16].
- `enable` output 1: high while a complete matrix is held; drives the downstream solvers.
- `mat_ack` input 1: the consumer has taken the held matrix.
- `subdiag_nz` output 3: bit k = (entry (k+1,k) != 0). The checked slices are bit0 = [79:64], bit1 = [159:144], bit2 = [239:224].
- `framing_err` output 1: one-cycle pulse on a framing violation.

## Operation
- Two-state FSM: FILL and HOLD.
  - Reset state is FILL with idx = 0.
- FILL:
  - `in_ready` = 1 and `enable` = 0.
  - An entry is accepted when `in_valid` && `in_ready`. It is written to slot idx of `A_new`, then idx increments. idx is a 4-bit counter.
  - The 16th accept (idx = 15) moves the FSM to HOLD. On the same edge, idx returns to 0 and `subdiag_nz` is registered from the final `A_new` contents, including the entry just written.
- HOLD:
  - `in_ready` = 0 and `enable` = 1.
  - `A_new` and `subdiag_nz` are frozen.
  - `mat_ack` = 1 moves the FSM to FILL on the next edge.
- `mat_ack` is ignored in FILL.
- `A_new` is not cleared between frames. Slots are overwritten in place as the next frame arrives. `enable` = 0 in FILL marks the contents as not yet valid.
- `subdiag_nz` updates only on the FILL to HOLD transition and is otherwise held.
- Framing rules:
  - `in_last` accepted with idx < 15: `framing_err` pulses, the partial frame is dropped, idx returns to 0, and the FSM stays in FILL. Already-written slots keep their new values.
  - idx = 15 accepted without `in_last`: `framing_err` pulses, but the frame is still completed and the FSM goes to HOLD.
  - `in_last` together with idx = 15 is normal and produces no error.
- `in_last` with `in_valid` = 0 is ignored.
- Reset at any time, including mid-frame or in HOLD: all outputs take their reset values immediately, idx = 0, and the FSM returns to FILL.
- Reset values:
  - `A_new` = 0, `enable` = 0, `subdiag_nz` = 0, `framing_err` = 0.
  - `in_ready` = 1 once reset deasserts; `in_ready` = 0 while `rst` is high.

## Timing
- An entry accepted on edge t is visible in `A_new` after edge t.
- For the 16th accept on edge t: `enable` = 1 and `subdiag_nz` are valid from t onward, i.e. in the cycle after the handshake cycle.
- `mat_ack` sampled high on edge t (in HOLD): `enable` = 0 and `in_ready` = 1 from t onward. The next entry can be accepted on edge t+1.
- Minimum period is 17 cycles per matrix: 16 accepts plus 1 ack cycle.
- `in_ready` is a function of state only; there is no combinational path from `in_valid`.
- `framing_err` is registered. It is high for exactly the one cycle after the offending accept.

## Test plan
- Reset, then stream entries 0x0001..0x0010 with `in_last` on the 16th entry:
  - `A_new`[15:0] = 0x0001 and `A_new`[255:240] = 0x0010.
  - `enable` rises the cycle after the 16th accept.
  - `subdiag_nz` = 3'b111 (the checked entries are 0x0005, 0x000A, 0x000F).
  - `in_ready` = 0 until ack.
- Frame with entries (1,0) = 0x3C00, (2,1) = 0x0000, (3,2) = 0xBC00 -> `subdiag_nz` = 3'b101.
- Hold the matrix for 10 cycles without ack, with `in_valid` = 1 throughout:
  - `A_new` is unchanged and no entry is accepted.
  - Pulse `mat_ack` -> `enable` drops the next cycle, and the next entry is accepted the cycle after that.
- `in_last` on the 7th entry -> `framing_err` pulses once, there is no HOLD, and the next 16 entries form a complete frame.
- 16th entry without `in_last` -> `framing_err` pulses and `enable` still rises.
- Assert `rst` after 9 accepts -> `A_new` = 0 and idx = 0. A fresh 16-entry frame then completes normally, and `mat_ack` issued during FILL has no effect.
